sdsu_bus_master_q: RTL

//  Synthesisable, parametrised SDSU bus master. Accepts read/write commands from a local requester

---
 rtl/sdsu_bus_master_q_if.sv | 48 ++++
 rtl/sdsu_bus_master_q.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sdsu_bus_master_q_if.sv
// sdsu_bus_master_q_if -- bundle of the requester-side command/response
// handshakes, the SDSU valid/ready bus and the status outputs of the
// sdsu_bus_master_q block.
//   master modport : the bus master (drives cmd_ready, rsp_*, bus_valid/addr/data, status)
//   slave  modport : the environment (drives cmd_*, rsp_ready, bus_ready/rdata)
// Parameters AW/DW/DEPTH must match the ones given to the master.
interface sdsu_bus_master_q_if #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // requester command
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  // requester response
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  // SDSU bus
  logic          bus_valid;
  logic          bus_we;
  logic [AW-1:0] bus_waddr;
  logic [DW-1:0] bus_wdata;
  logic [AW-1:0] bus_raddr;
  logic [DW-1:0] bus_rdata;
  logic          bus_ready;
  // status
  logic [CW-1:0] cmd_count;
  logic          busy;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, bus_rdata, bus_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           bus_valid, bus_we, bus_waddr, bus_wdata, bus_raddr, cmd_count, busy
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, bus_rdata, bus_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           bus_valid, bus_we, bus_waddr, bus_wdata, bus_raddr, cmd_count, busy
  );
endinterface

// File: rtl/sdsu_bus_master_q.sv
// sdsu_bus_master_q -- queued SDSU bus master.
// Commands from a local requester land in a DEPTH-entry FIFO, are issued one
// at a time on the valid/ready SDSU bus, and each produces exactly one
// in-order response.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sdsu_bus_master_q_if.master (cmd_*, rsp_*, bus_*, cmd_count, busy)
// Optional feature: define SDSU_BUS_TIMEOUT_EN to abort a bus request that has
// waited TIMEOUT_CYC cycles without bus_ready (response returns rsp_err=1).
module sdsu_bus_master_q #(
  parameter int AW          = 5,
  parameter int DW          = 32,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sdsu_bus_master_q_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  state_t        r_state, w_next;
  cmd_t          r_mem [DEPTH];
  cmd_t          w_head;
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop, w_done, w_tmo, w_full;

  logic          r_bus_we;
  logic [AW-1:0] r_bus_waddr, r_bus_raddr;
  logic [DW-1:0] r_bus_wdata, r_rsp_rdata;

  // ---------------- command FIFO ----------------
  assign w_full = (r_count == CW'(DEPTH));
  assign w_push = bus.cmd_valid && !w_full;
  assign w_head = r_mem[r_rptr];

  // storage carries no reset: pointers/count define what is valid
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= '{we: bus.cmd_we, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // pop only from IDLE, so an empty-FIFO push reaches the bus one cycle later
  // and a finished response always leaves one IDLE cycle before the next request
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_IDLE: if (r_count != '0) begin
        w_pop  = 1'b1;
        w_next = S_REQ;
      end
      S_REQ: if (bus.bus_ready || w_tmo) begin
        w_done = 1'b1;
        w_next = S_RSP;
      end
      S_RSP: if (bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- bus / response registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_we    <= 1'b0;
      r_bus_waddr <= '0;
      r_bus_wdata <= '0;
      r_bus_raddr <= '0;
      r_rsp_rdata <= '0;
    end else begin
      if (w_pop) begin
        r_bus_we    <= w_head.we;
        r_bus_waddr <= w_head.we ? w_head.addr  : '0;
        r_bus_wdata <= w_head.we ? w_head.wdata : '0;
        r_bus_raddr <= w_head.we ? '0 : w_head.addr;
      end
      // a timed-out read has no bus_ready and so also returns 0
      if (w_done) r_rsp_rdata <= (!r_bus_we && bus.bus_ready) ? bus.bus_rdata : '0;
    end
  end

`ifdef SDSU_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_wait;
  logic          r_rsp_err;

  // r_wait == TIMEOUT_CYC-1 in REQ means this edge would be the TIMEOUT_CYC-th
  // edge without bus_ready; bus_ready on that same edge still completes normally
  assign w_tmo = (r_state == S_REQ) && (r_wait == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait    <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (w_pop)                                   r_wait <= '0;
      else if (r_state == S_REQ && !bus.bus_ready) r_wait <= r_wait + TW'(1);
      if (w_done) r_rsp_err <= !bus.bus_ready;
    end
  end

  assign bus.rsp_err = r_rsp_err;
`else
  assign w_tmo       = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  // ---------------- outputs ----------------
  // valid flags decode the async-reset state register, so reset drops them at once
  assign bus.cmd_ready = !w_full;
  assign bus.cmd_count = r_count;
  assign bus.busy      = (r_state != S_IDLE) || (r_count != '0);
  assign bus.bus_valid = (r_state == S_REQ);
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_waddr = r_bus_waddr;
  assign bus.bus_wdata = r_bus_wdata;
  assign bus.bus_raddr = r_bus_raddr;
  assign bus.rsp_valid = (r_state == S_RSP);
  assign bus.rsp_rdata = r_rsp_rdata;
endmodule
